// File: rtl/core_test_sequencer_if.sv
// Bundles the core-under-test control/observation signals and the data-memory dump port.
interface core_test_sequencer_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    logic                  core_rst;
    logic [31:0]           core_pc;
    logic                  dump_en;
    logic [ADDR_WIDTH-1:0] dump_addr;
    logic [DATA_WIDTH-1:0] dump_data;
    logic [DATA_WIDTH-1:0] exp_data;

    modport master (
        output core_rst, dump_en, dump_addr,
        input  core_pc, dump_data, exp_data
    );

    modport slave (
        input  core_rst, dump_en, dump_addr,
        output core_pc, dump_data, exp_data
    );
endinterface

// File: rtl/core_test_sequencer.sv
// Test harness controller: resets the core, runs until PC halt or timeout,
// then scans data memory against an expected image and reports the result.
module core_test_sequencer #(
    parameter int DATA_WIDTH     = 32,
    parameter int MEM_DEPTH      = 32,
    parameter int ADDR_WIDTH     = 5,
    parameter int RESET_CYCLES   = 2,
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int HALT_STABLE    = 4     // must be >= 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start_i,
    core_test_sequencer_if.master   tb_if,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    pass_o,
    output logic                    timed_out_o,
    output logic [ADDR_WIDTH:0]     fail_count_o,
    output logic [ADDR_WIDTH-1:0]   first_fail_addr_o
);

    typedef enum logic [2:0] {IDLE, RESET, RUN, DUMP, DRAIN, DONE} state_t;

    localparam int RCW = (RESET_CYCLES   > 1) ? $clog2(RESET_CYCLES)   : 1;
    localparam int TCW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int SCW = (HALT_STABLE    > 1) ? $clog2(HALT_STABLE)    : 1;

    localparam logic [RCW-1:0]        RST_LAST  = RCW'(RESET_CYCLES - 1);
    localparam logic [TCW-1:0]        RUN_LAST  = TCW'(TIMEOUT_CYCLES - 1);
    localparam logic [SCW-1:0]        STB_LAST  = SCW'(HALT_STABLE - 2);
    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(MEM_DEPTH - 1);

    state_t                state_q, state_d;
    logic [RCW-1:0]        rst_cnt_q, rst_cnt_d;
    logic [TCW-1:0]        run_cnt_q, run_cnt_d;
    logic [SCW-1:0]        stable_q, stable_d;
    logic [31:0]           pc_q;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  cmp_vld_q;
    logic [ADDR_WIDTH-1:0] cmp_addr_q;
    logic [ADDR_WIDTH:0]   fail_q, fail_d;
    logic [ADDR_WIDTH-1:0] first_q, first_d;
    logic                  to_q, to_d;
    logic                  pass_q, pass_d;
    logic                  core_rst_q, dump_en_q, busy_q, done_q;
    logic                  halt, timeout, mismatch;

    // NOTE: every signal gets a default before the case so no path can leave it unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        rst_cnt_d = rst_cnt_q;
        run_cnt_d = run_cnt_q;
        stable_d  = stable_q;
        addr_d    = addr_q;
        fail_d    = fail_q;
        first_d   = first_q;
        to_d      = to_q;
        pass_d    = pass_q;
        halt      = 1'b0;
        timeout   = 1'b0;
        mismatch  = cmp_vld_q && (tb_if.dump_data != tb_if.exp_data);

        unique case (state_q)
            IDLE, DONE: begin
                if (start_i) begin
                    state_d   = RESET;
                    rst_cnt_d = '0;
                    fail_d    = '0;
                    first_d   = '0;
                    to_d      = 1'b0;
                    pass_d    = 1'b0;
                end
            end
            RESET: begin
                if (rst_cnt_q == RST_LAST) begin
                    state_d   = RUN;
                    run_cnt_d = '0;
                    stable_d  = '0;
                end else begin
                    rst_cnt_d = rst_cnt_q + 1'b1;
                end
            end
            RUN: begin
                run_cnt_d = run_cnt_q + 1'b1;
                if (tb_if.core_pc == pc_q) begin
                    if (stable_q == STB_LAST) halt = 1'b1;
                    else                      stable_d = stable_q + 1'b1;
                end else begin
                    stable_d = '0;
                end
                timeout = !halt && (run_cnt_q == RUN_LAST);
                if (timeout) to_d = 1'b1;
                if (halt || timeout) begin
                    state_d = DUMP;
                    addr_d  = '0;
                end
            end
            DUMP: begin
                if (addr_q == ADDR_LAST) state_d = DRAIN;
                else                     addr_d  = addr_q + 1'b1;
            end
            DRAIN:   state_d = DONE;
            default: state_d = IDLE;
        endcase

        // Read data lags the issued address by one cycle, so the compare uses the delayed address.
        if (mismatch) begin
            fail_d = fail_q + 1'b1;
            if (fail_q == '0) first_d = cmp_addr_q;
        end
        if (state_q == DRAIN) pass_d = (fail_d == '0) && !to_q;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            rst_cnt_q  <= '0;
            run_cnt_q  <= '0;
            stable_q   <= '0;
            pc_q       <= '0;
            addr_q     <= '0;
            cmp_vld_q  <= 1'b0;
            cmp_addr_q <= '0;
            fail_q     <= '0;
            first_q    <= '0;
            to_q       <= 1'b0;
            pass_q     <= 1'b0;
            core_rst_q <= 1'b1;
            dump_en_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rst_cnt_q  <= rst_cnt_d;
            run_cnt_q  <= run_cnt_d;
            stable_q   <= stable_d;
            pc_q       <= tb_if.core_pc;
            addr_q     <= addr_d;
            cmp_vld_q  <= dump_en_q;
            cmp_addr_q <= addr_q;
            fail_q     <= fail_d;
            first_q    <= first_d;
            to_q       <= to_d;
            pass_q     <= pass_d;
            core_rst_q <= (state_d != RUN);
            dump_en_q  <= (state_d == DUMP);
            busy_q     <= (state_d inside {RESET, RUN, DUMP, DRAIN});
            done_q     <= (state_d == DONE);
        end
    end

    assign tb_if.core_rst    = core_rst_q;
    assign tb_if.dump_en     = dump_en_q;
    assign tb_if.dump_addr   = addr_q;
    assign busy_o            = busy_q;
    assign done_o            = done_q;
    assign pass_o            = pass_q;
    assign timed_out_o       = to_q;
    assign fail_count_o      = fail_q;
    assign first_fail_addr_o = first_q;

endmodule

// File: tb/tb_core_test_sequencer.sv
// Directed bench: halt run, mismatches, boundary addresses, timeout, halt/timeout tie, reset mid-dump.
module tb_core_test_sequencer;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          busy, done, pass, timed_out;
    logic [AW:0]   fail_count;
    logic [AW-1:0] first_fail_addr;

    logic [DW-1:0] mem  [DEPTH];
    logic [DW-1:0] expv [DEPTH];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    core_test_sequencer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    core_test_sequencer #(
        .DATA_WIDTH    (DW),
        .MEM_DEPTH     (DEPTH),
        .ADDR_WIDTH    (AW),
        .RESET_CYCLES  (2),
        .TIMEOUT_CYCLES(50),
        .HALT_STABLE   (4)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .start_i          (start),
        .tb_if            (bus),
        .busy_o           (busy),
        .done_o           (done),
        .pass_o           (pass),
        .timed_out_o      (timed_out),
        .fail_count_o     (fail_count),
        .first_fail_addr_o(first_fail_addr)
    );

    // Synchronous-read memory and expected image: data appears the cycle after dump_en.
    always @(posedge clk) begin
        if (bus.dump_en) begin
            bus.dump_data <= mem[bus.dump_addr];
            bus.exp_data  <= expv[bus.dump_addr];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic load_images();
        for (int i = 0; i < DEPTH; i++) begin
            mem[i]  = 32'hA5A5_0000 ^ (32'(i) * 32'h0101_0101);
            expv[i] = mem[i];
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Start pulse plus two RESET cycles; returns in the first RUN cycle.
    task automatic enter_run();
        pulse_start();
        tick();
        tick();
    endtask

    // PCs 0,4,8,C,C,C; the caller supplies the final C that triggers halt.
    task automatic pc_prefix();
        logic [31:0] seq [6];
        seq = '{32'h0, 32'h4, 32'h8, 32'hC, 32'hC, 32'hC};
        for (int i = 0; i < 6; i++) begin
            bus.core_pc = seq[i];
            tick();
        end
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!done && n < 100) begin
            tick();
            n++;
        end
        check(name, done, 1'b1);
    endtask

    initial begin
        rst         = 1'b1;
        start       = 1'b0;
        bus.core_pc = '0;
        load_images();
        repeat (3) tick();

        check("rst_core_rst",   bus.core_rst, 1'b1);
        check("rst_dump_en",    bus.dump_en, 1'b0);
        check("rst_dump_addr",  bus.dump_addr, 0);
        check("rst_busy",       busy, 1'b0);
        check("rst_done",       done, 1'b0);
        check("rst_pass",       pass, 1'b0);
        check("rst_timed_out",  timed_out, 1'b0);
        check("rst_fail_count", fail_count, 0);
        check("rst_first_fail", first_fail_addr, 0);
        rst = 1'b0;
        tick();
        check("idle_busy", busy, 1'b0);

        // Run A: halt on stable PC, matching images.
        pulse_start();
        check("A_rst_hold1", bus.core_rst, 1'b1);
        check("A_busy",      busy, 1'b1);
        tick();
        check("A_rst_hold2", bus.core_rst, 1'b1);
        tick();
        check("A_rst_release", bus.core_rst, 1'b0);
        check("A_run_busy",    busy, 1'b1);
        pc_prefix();
        check("A_no_early_halt", bus.dump_en, 1'b0);
        bus.core_pc = 32'hC;
        tick();
        check("A_dump_en",       bus.dump_en, 1'b1);
        check("A_dump_addr0",    bus.dump_addr, 0);
        check("A_core_rst_dump", bus.core_rst, 1'b1);
        for (int i = 1; i < DEPTH; i++) begin
            tick();
            check("A_dump_addr", bus.dump_addr, i);
        end
        check("A_dump_en_last", bus.dump_en, 1'b1);
        tick();
        check("A_drain_en",   bus.dump_en, 1'b0);
        check("A_drain_done", done, 1'b0);
        tick();
        check("A_done",       done, 1'b1);
        check("A_done_busy",  busy, 1'b0);
        check("A_pass",       pass, 1'b1);
        check("A_fail_count", fail_count, 0);
        check("A_first_fail", first_fail_addr, 0);
        check("A_timed_out",  timed_out, 1'b0);
        repeat (3) tick();
        check("A_hold_done", done, 1'b1);
        check("A_hold_pass", pass, 1'b1);

        // Run B: mismatches at 7 and 20; start held high during RUN is ignored.
        expv[7]  = expv[7] ^ 32'h0000_0001;
        expv[20] = expv[20] ^ 32'h8000_0000;
        pulse_start();
        check("B_restart_done", done, 1'b0);
        check("B_restart_pass", pass, 1'b0);
        tick();
        tick();
        start = 1'b1;
        pc_prefix();
        start = 1'b0;
        bus.core_pc = 32'hC;
        tick();
        check("B_halt_start_ignored", bus.dump_en, 1'b1);
        wait_done("B_done");
        check("B_fail_count", fail_count, 2);
        check("B_first_fail", first_fail_addr, 7);
        check("B_pass",       pass, 1'b0);
        check("B_timed_out",  timed_out, 1'b0);

        // Run C: only the last word mismatches, caught by the drain compare.
        load_images();
        expv[DEPTH-1] = ~expv[DEPTH-1];
        enter_run();
        pc_prefix();
        bus.core_pc = 32'hC;
        tick();
        wait_done("C_done");
        check("C_fail_count", fail_count, 1);
        check("C_first_fail", first_fail_addr, DEPTH-1);
        check("C_pass",       pass, 1'b0);

        // Run D: first and last words mismatch.
        expv[0] = ~expv[0];
        enter_run();
        pc_prefix();
        bus.core_pc = 32'hC;
        tick();
        wait_done("D_done");
        check("D_fail_count", fail_count, 2);
        check("D_first_fail", first_fail_addr, 0);

        // Run E: PC never stalls, timeout after 50 RUN cycles.
        load_images();
        enter_run();
        for (int n = 0; n < 49; n++) begin
            bus.core_pc = 32'h100 + 32'(4 * n);
            tick();
        end
        check("E_no_early_timeout", bus.dump_en, 1'b0);
        bus.core_pc = 32'h100 + 32'(4 * 49);
        tick();
        check("E_timeout_dump", bus.dump_en, 1'b1);
        check("E_timed_out",    timed_out, 1'b1);
        wait_done("E_done");
        check("E_pass",       pass, 1'b0);
        check("E_fail_count", fail_count, 0);
        check("E_timed_out_done", timed_out, 1'b1);

        // Run F: halt and timeout on the same cycle; halt wins.
        enter_run();
        for (int n = 0; n < 47; n++) begin
            bus.core_pc = 32'h200 + 32'(4 * n);
            tick();
        end
        repeat (2) tick();
        check("F_not_yet", bus.dump_en, 1'b0);
        tick();
        check("F_dump",      bus.dump_en, 1'b1);
        check("F_timed_out", timed_out, 1'b0);
        wait_done("F_done");
        check("F_pass", pass, 1'b1);

        // Run G: async reset in the middle of the dump, then a clean restart.
        expv[3] = ~expv[3];
        enter_run();
        pc_prefix();
        bus.core_pc = 32'hC;
        tick();
        repeat (10) tick();
        check("G_addr10",      bus.dump_addr, 10);
        check("G_fail_before", fail_count, 1);
        #2 rst = 1'b1;
        #1;
        check("G_rst_core_rst", bus.core_rst, 1'b1);
        check("G_rst_dump_en",  bus.dump_en, 1'b0);
        check("G_rst_addr",     bus.dump_addr, 0);
        check("G_rst_busy",     busy, 1'b0);
        check("G_rst_fail",     fail_count, 0);
        check("G_rst_first",    first_fail_addr, 0);
        tick();
        rst = 1'b0;
        tick();
        check("G_idle_done", done, 1'b0);
        load_images();
        pulse_start();
        check("G_restart_core_rst", bus.core_rst, 1'b1);
        check("G_restart_busy",     busy, 1'b1);
        tick();
        tick();
        check("G_restart_run", bus.core_rst, 1'b0);
        pc_prefix();
        bus.core_pc = 32'hC;
        tick();
        check("G_restart_dump", bus.dump_en, 1'b1);
        wait_done("G_done");
        check("G_pass", pass, 1'b1);
        check("G_fail_count", fail_count, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
